// File: rtl/fft8_stage_sequencer.sv
// fft8_stage_sequencer: control FSM for the in-place radix-2 DIF FFT engine.
// It sequences sample load, LOG2N butterfly stages and a bit-reversed drain.
// It also generates the operand addresses and twiddle indices, and holds
// BF_LAT+1 idle cycles between stages so the butterfly pipeline can finish
// writing back.
module fft8_stage_sequencer #(
    parameter int LOG2N  = 3,
    parameter int BF_LAT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LOG2N-1:0] in_addr,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] bf_addr_a,
    output logic [LOG2N-1:0] bf_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic [1:0]       stage,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOG2N-1:0] out_addr,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int               N          = 1 << LOG2N;
    localparam int               TW_W       = LOG2N - 1;
    localparam logic [LOG2N-1:0] LAST       = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] HALF_LAST  = LOG2N'(N / 2 - 1);
    localparam logic [1:0]       LAST_STAGE = 2'(LOG2N - 1);
    localparam logic [2:0]       LAT_INIT   = 3'(BF_LAT);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;       // sample index, butterfly index or drain index
    logic [1:0]       stage_q, stage_d;
    logic [2:0]       lat_q, lat_d;
    logic             done_q, done_d;

    logic [LOG2N-1:0] span, pos, grp, addr_a;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // Butterfly address generation for stage stage_q, butterfly cnt_q.
    always_comb begin
        span   = LOG2N'(N >> (int'(stage_q) + 1));
        pos    = cnt_q & (span - LOG2N'(1));
        grp    = cnt_q >> (LOG2N - 1 - int'(stage_q));
        addr_a = (grp << (LOG2N - int'(stage_q))) | pos;
    end

    // State, counters and the registered done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            lat_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            lat_q   <= lat_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic and state-gated outputs (all zero while IDLE).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        lat_d     = lat_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        in_addr   = '0;
        bf_valid  = 1'b0;
        bf_addr_a = '0;
        bf_addr_b = '0;
        tw_idx    = '0;
        out_valid = 1'b0;
        out_addr  = '0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                in_addr  = cnt_q;
                if (in_valid) begin
                    if (cnt_q == LAST) begin
                        state_d = ISSUE;
                        cnt_d   = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
            ISSUE: begin
                bf_valid  = 1'b1;
                bf_addr_a = addr_a;
                bf_addr_b = addr_a + span;
                tw_idx    = TW_W'(pos << stage_q);
                if (bf_ready) begin
                    if (cnt_q == HALF_LAST) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        lat_d   = LAT_INIT;
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
            WAIT: begin
                if (lat_q == 3'd0) begin
                    cnt_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                        stage_d = stage_q + 2'd1;
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_addr  = bitrev(cnt_q);
                out_last  = (cnt_q == LAST);
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        stage_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stage = stage_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_fft8_stage_sequencer.sv
// Testbench for fft8_stage_sequencer: two instances (BF_LAT=2 and BF_LAT=0),
// scoreboard queues of expected butterflies and drain addresses.
module tb_fft8_stage_sequencer;

    localparam int LOG2N = 3;
    localparam int N     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start [2];
    logic       in_valid [2];
    logic       bf_ready [2];
    logic       out_ready [2];
    logic       in_ready [2];
    logic       bf_valid [2];
    logic       out_valid [2];
    logic       out_last [2];
    logic       busy [2];
    logic       done [2];
    logic [2:0] in_addr [2];
    logic [2:0] bf_addr_a [2];
    logic [2:0] bf_addr_b [2];
    logic [2:0] out_addr [2];
    logic [1:0] tw_idx [2];
    logic [1:0] stage [2];

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {int s; int b; int a; int bb; int tw;} bf_t;
    bf_t bfq[$];
    int  drq[$];
    int  rev8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int  orpat [4] = '{1, 0, 0, 1};

    fft8_stage_sequencer #(.LOG2N(3), .BF_LAT(2)) u_lat2 (
        .clk(clk), .reset_n(reset_n), .start(start[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_addr(in_addr[0]),
        .bf_valid(bf_valid[0]), .bf_ready(bf_ready[0]),
        .bf_addr_a(bf_addr_a[0]), .bf_addr_b(bf_addr_b[0]), .tw_idx(tw_idx[0]),
        .stage(stage[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_addr(out_addr[0]), .out_last(out_last[0]), .busy(busy[0]), .done(done[0])
    );

    fft8_stage_sequencer #(.LOG2N(3), .BF_LAT(0)) u_lat0 (
        .clk(clk), .reset_n(reset_n), .start(start[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_addr(in_addr[1]),
        .bf_valid(bf_valid[1]), .bf_ready(bf_ready[1]),
        .bf_addr_a(bf_addr_a[1]), .bf_addr_b(bf_addr_b[1]), .tw_idx(tw_idx[1]),
        .stage(stage[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_addr(out_addr[1]), .out_last(out_last[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        chk({tag, "_busy"},      busy[d],      0);
        chk({tag, "_in_ready"},  in_ready[d],  0);
        chk({tag, "_in_addr"},   in_addr[d],   0);
        chk({tag, "_bf_valid"},  bf_valid[d],  0);
        chk({tag, "_bf_addr_a"}, bf_addr_a[d], 0);
        chk({tag, "_bf_addr_b"}, bf_addr_b[d], 0);
        chk({tag, "_tw_idx"},    tw_idx[d],    0);
        chk({tag, "_stage"},     stage[d],     0);
        chk({tag, "_out_valid"}, out_valid[d], 0);
        chk({tag, "_out_addr"},  out_addr[d],  0);
        chk({tag, "_out_last"},  out_last[d],  0);
        chk({tag, "_done"},      done[d],      0);
    endtask

    // One full transform on instance d with optional input gaps, a 3-cycle
    // butterfly stall at (stall_s,stall_b), out_ready toggling and start spam.
    task automatic run(input int d, input int lat, input int in_gap, input int stall_s,
                       input int stall_b, input int or_toggle, input int start_spam);
        bf_t e;
        int  edges, ld, gap, stalls, stall_left, k_in, k_out, span;
        bit  seen_done;
        bfq.delete();
        drq.delete();
        for (int s = 0; s < LOG2N; s++) begin
            span = N >> (s + 1);
            for (int b = 0; b < N / 2; b++) begin
                e.s  = s;
                e.b  = b;
                e.a  = (b / span) * 2 * span + (b % span);
                e.bb = e.a + span;
                e.tw = (b % span) << s;
                bfq.push_back(e);
            end
        end
        for (int j = 0; j < N; j++) drq.push_back(rev8[j]);

        @(negedge clk);
        start[d] = 1'b1;
        edges = 0; ld = 0; gap = 0; stalls = 0; stall_left = 3;
        k_in = 0; k_out = 0; seen_done = 1'b0;
        while (!seen_done && edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start[d]     = (start_spam != 0) && busy[d] && (edges % 2 == 1);
            in_valid[d]  = 1'b0;
            bf_ready[d]  = 1'b0;
            out_ready[d] = 1'b0;
            if (done[d]) begin
                seen_done = 1'b1;
                chk("start_to_done", edges - 1, N + LOG2N * (N / 2 + lat + 1) + N + stalls);
                chk("bf_left", bfq.size(), 0);
                chk("beats_left", drq.size(), 0);
            end
            if (in_ready[d]) begin
                chk("in_addr", in_addr[d], ld);
                in_valid[d] = !(in_gap != 0 && (k_in % 3 == 1));
                if (in_valid[d]) ld++;
                else stalls++;
                k_in++;
            end
            if (bf_valid[d]) begin
                if (bfq.size() == 0) begin
                    chk("bf_extra", 1, 0);
                end else begin
                    e = bfq[0];
                    if (e.s > 0 && e.b == 0 && gap >= 0) chk("stage_gap", gap, lat + 1);
                    gap = -1;
                    chk("bf_stage", stage[d], e.s);
                    chk("bf_addr_a", bf_addr_a[d], e.a);
                    chk("bf_addr_b", bf_addr_b[d], e.bb);
                    chk("tw_idx", tw_idx[d], e.tw);
                    if (e.s == stall_s && e.b == stall_b && stall_left > 0) begin
                        stall_left--;
                        stalls++;
                    end else begin
                        bf_ready[d] = 1'b1;
                        void'(bfq.pop_front());
                    end
                end
            end else if (busy[d] && !in_ready[d] && !out_valid[d]) begin
                gap = (gap < 0) ? 1 : gap + 1;
            end
            if (out_valid[d]) begin
                if (k_out == 0) chk("drain_gap", gap, lat + 1);
                gap = -1;
                if (drq.size() == 0) begin
                    chk("beat_extra", 1, 0);
                end else begin
                    chk("out_addr", out_addr[d], drq[0]);
                    chk("out_last", out_last[d], (drq.size() == 1) ? 1 : 0);
                    out_ready[d] = (or_toggle != 0) ? orpat[k_out % 4][0] : 1'b1;
                    if (out_ready[d]) void'(drq.pop_front());
                    else stalls++;
                    k_out++;
                end
            end
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        start[d]     = 1'b0;
        in_valid[d]  = 1'b0;
        bf_ready[d]  = 1'b0;
        out_ready[d] = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done[d], 0);
        chk("busy_after_done", busy[d], 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; in_valid[i] = 1'b0; bf_ready[i] = 1'b0; out_ready[i] = 1'b0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle(0, "rst_a");
        check_idle(1, "rst_b");
        reset_n = 1'b1;
        @(negedge clk);

        // Plain transform: issue sequence, drain order, 37-cycle latency.
        run(0, 2, 0, -1, -1, 0, 0);
        // Butterfly backpressure at stage 1, butterfly 1.
        run(0, 2, 0, 1, 1, 0, 0);
        // Output backpressure 1,0,0,1 with start pulses while busy.
        run(0, 2, 0, -1, -1, 1, 1);
        // Zero butterfly latency with input gaps.
        run(1, 0, 1, -1, -1, 0, 0);

        // Asynchronous reset in the middle of ISSUE.
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0]    = 1'b0;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 20 && !bf_valid[0]; i++) @(negedge clk);
        chk("t1_reach_issue", bf_valid[0], 1);
        bf_ready[0] = 1'b1;
        @(negedge clk);
        chk("t1_mid_issue", stage[0], 0);
        #2 reset_n = 1'b0;
        #1 check_idle(0, "t1_async");
        @(negedge clk);
        check_idle(0, "t1_held");
        in_valid[0] = 1'b0;
        bf_ready[0] = 1'b0;
        reset_n     = 1'b1;
        @(negedge clk);
        check_idle(0, "t1_release");
        run(0, 2, 0, -1, -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
